imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 107 ++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: assembles big-endian words from a byte
// handshake and issues one write per word until a halt word or capacity is hit.
module imem_loader #(
    parameter int unsigned        NB_DATA   = 32,
    parameter int unsigned        MEM_SIZEB = 128,
    parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_byte_valid,
    input  logic [7:0]         i_byte,
    output logic               o_byte_ready,
    output logic               o_en_write,
    output logic [NB_DATA-1:0] o_addr,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_full,
    output logic [NB_DATA-1:0] o_word_count
);

    localparam logic [NB_DATA-1:0] One      = NB_DATA'(1);
    localparam logic [NB_DATA-1:0] MemWords = NB_DATA'(MEM_SIZEB);

    typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

    state_e             state_q, state_d;
    logic [1:0]         byte_idx_q;
    logic [NB_DATA-1:0] addr_q;
    logic [NB_DATA-1:0] data_q;
    logic [NB_DATA-1:0] word_count_q;
    logic [NB_DATA-1:0] word_count_inc;
    logic               full_q;
    logic               byte_accept;
    logic               is_halt;
    logic               is_last;
    logic               start_session;

    assign byte_accept    = i_byte_valid && (state_q == StRecv);
    assign word_count_inc = word_count_q + One;
    assign is_halt        = (data_q == HALT_WORD);
    assign is_last        = (word_count_inc == MemWords);
    assign start_session  = i_start && ((state_q == StIdle) || (state_q == StDone));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_start) state_d = StRecv;
            StRecv:  if (byte_accept && (byte_idx_q == 2'd3)) state_d = StWrite;
            // Halt is checked first so a halt word in the last slot is not flagged full.
            StWrite: begin
                if (is_halt || is_last) state_d = StDone;
                else                    state_d = StRecv;
            end
            StDone:  if (i_start) state_d = StRecv;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_byte_ready = (state_q == StRecv);
        o_en_write   = (state_q == StWrite);
        o_busy       = (state_q == StRecv) || (state_q == StWrite);
        o_done       = (state_q == StDone);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            byte_idx_q   <= 2'd0;
            addr_q       <= '0;
            data_q       <= '0;
            word_count_q <= '0;
            full_q       <= 1'b0;
        end else begin
            if (start_session) begin
                byte_idx_q   <= 2'd0;
                addr_q       <= '0;
                word_count_q <= '0;
                full_q       <= 1'b0;
            end
            if (byte_accept) begin
                data_q[(NB_DATA - 8) - 8 * int'(byte_idx_q) +: 8] <= i_byte;
                byte_idx_q <= byte_idx_q + 2'd1;
            end
            if (state_q == StWrite) begin
                addr_q       <= addr_q + One;
                word_count_q <= word_count_inc;
                if (!is_halt && is_last) full_q <= 1'b1;
            end
        end
    end

    assign o_addr       = addr_q;
    assign o_data       = data_q;
    assign o_full       = full_q;
    assign o_word_count = word_count_q;

endmodule
